booth_product_accumulator: RTL
==============================

# booth_product_accumulator

Streaming accumulator that sits directly downstream of the 8x8 radix-4 Booth multiplier. It accepts one signed 16-bit product per cycle over a valid/ready handshake and sums a frame of products terminated by a `last` flag. It then presents the frame's sign-extended sum, term count and overflow flag on an output valid/ready handshake. It turns the combinational multiplier into the back end of a multiply-accumulate (dot-product) path.

## Interface
- `ACC_W`, default 24: accumulator and output sum width in bits; must be at least 17.
- `CNT_W`, default 8: term-counter width in bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_product`/`in_last` valid this cycle.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_product`  in  16  two's-complement product from the multiplier.
- `in_last`  in  1  final beat of the current frame.
- `out_valid`  out  1  frame result held on the out_* ports.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  signed frame sum.
- `out_count`  out  CNT_W  number of beats in the frame, saturating.
- `out_overflow`  out  1  sum saturated at some point in the frame, or the count saturated.

## Operation
- The FSM has two states, ACCUM and HOLD. Reset enters ACCUM.
- A beat is accepted on `in_valid & in_ready`.
- `in_ready` = 1 in ACCUM and 0 in HOLD. It has no combinational dependence on `out_ready`.
- **Arithmetic:** `in_product` is sign-extended to ACC_W+1 bits, then added to the sign-extended accumulator.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to 2^(ACC_W-1)-1.
  - If the result is below -2^(ACC_W-1), clamp to -2^(ACC_W-1).
  - Any clamp sets the sticky frame-overflow bit.
  - Saturation is per beat: later beats continue from the clamped value.
- **Count:** increments per accepted beat and saturates at 2^CNT_W-1. Reaching saturation and then accepting another beat also sets the overflow bit.
- **ACCUM, beat accepted with in_last = 0:** update the accumulator, count and overflow bit. Stay in ACCUM.
- **ACCUM, beat accepted with in_last = 1:**
  - Load `out_sum`, `out_count` and `out_overflow` from the updated values, including this beat.
  - Clear the internal accumulator, count and overflow bit.
  - Assert `out_valid`. Go to HOLD.
- **HOLD:** out_* stay stable until `out_valid & out_ready`.
  - On that handshake, deassert `out_valid` and return to ACCUM.
  - No input beat is accepted in the same cycle as the handshake.
- A single-beat frame (first beat has in_last = 1) is legal and gives count = 1.
- Idle cycles (in_valid = 0) inside a frame leave all state unchanged.
- **Reset mid-frame or in HOLD:** discards the partial sum and any pending result. No output handshake occurs for the discarded frame.

## Timing
- **Reset values:** `in_ready` = 1 in the cycle after `rst` is released. `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_overflow` = 0. Internal accumulator, count, overflow bit and FSM state (ACCUM) are cleared.
- **Latency:** `out_valid` rises on the clock edge that accepts the `in_last` beat, so the result is visible one cycle after that beat is presented.
- **Throughput:** one beat per cycle within a frame. There is at least one bubble per frame, because `in_ready` = 0 for one or more cycles while in HOLD.
- **Output handshake:** once raised, `out_valid` stays high and out_* stay constant until accepted, whatever the input signals do. The earliest next-frame beat is accepted the cycle after the output handshake.
- **Registered outputs:** all outputs come straight from flops or FSM decode. There is no combinational input-to-output path.

## Test plan
- **Basic frame:** reset 2 cycles, then beats 100, 0xFFEB (-21), 5, last on the third, with out_ready = 1.
  - out_valid rises the cycle after the third beat, with out_sum = 84 and out_count = 3.
  - out_overflow = 0. in_ready = 0 for exactly one cycle.
- **Back-pressure:** single beat 0x8000 (-32768) with in_last, and out_ready held 0 for 5 cycles.
  - out_sum = 0xFF8000 (ACC_W = 24) and out_count = 1, both stable for all 5 cycles.
  - in_ready stays 0 while in HOLD. A beat presented during HOLD is not consumed. It is accepted as the next frame only after the output handshake.
- **Saturation (ACC_W = 18):** 8 beats of 16384 (0x4000), the last with in_last.
  - out_sum = 131071, out_count = 8, out_overflow = 1.
  - A following frame with the single beat 1 gives sum 1 and overflow 0.
- **Count saturation (CNT_W = 3):** 9 beats of 1.
  - out_count = 7, out_overflow = 1, out_sum = 9.
- **Mid-frame reset:** 2 beats of 1000, then assert rst for 1 cycle.
  - All outputs become 0 and in_ready = 1.
  - A following frame with beats 3 and 4 gives out_sum = 7 and out_count = 2.
- **Gapped input:** beats -5 and 7 separated by 3 idle cycles, then last beat 0.
  - out_sum = 2 and out_count = 3. in_valid gaps do not change the result.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_accumulator_if
// Purpose  : Streaming bus between the Booth multiplier side and the frame
//            accumulator. It carries one product per beat in and one frame
//            result out, each on its own valid/ready handshake.
// Ports    : none (signal bundle only)
//            master : drives in_valid/in_product/in_last and out_ready
//            slave  : drives in_ready and out_valid/out_sum/out_count/out_overflow
// Revision : 1.0 - initial release
// ============================================================================
interface booth_product_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_accumulator
// Purpose  : Sums a frame of signed 16-bit products into a saturating ACC_W-bit
//            accumulator. It presents the frame sum, the saturating term count
//            and a sticky overflow flag once the in_last beat is accepted.
// Ports    : clk  - single clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - slave side of booth_product_accumulator_if
//                   (in_valid/in_ready/in_product/in_last,
//                    out_valid/out_ready/out_sum/out_count/out_overflow)
// Revision : 1.0 - initial release
// ============================================================================
module booth_product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    booth_product_accumulator_if.slave       bus
);
    localparam int               c_EXT_W   = ACC_W + 1 - 16;
    localparam logic [ACC_W-1:0] c_SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic             w_out_fire;
    logic [ACC_W:0]   w_sum_wide;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_sum_clamp;
    logic             w_cnt_full;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ovf_next;

    assign w_accept   = bus.in_valid && (r_state == ST_ACCUM);
    assign w_out_fire = (r_state == ST_HOLD) && bus.out_ready;

    // One guard bit above the accumulator. The sum overflowed exactly when
    // the guard bit disagrees with the accumulator's sign bit, and the guard
    // bit then gives the true sign, which selects the clamp direction.
    assign w_sum_wide  = {{c_EXT_W{bus.in_product[15]}}, bus.in_product}
                       + {r_acc[ACC_W-1], r_acc};
    assign w_sum_clamp = w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1];
    assign w_acc_next  = !w_sum_clamp       ? w_sum_wide[ACC_W-1:0] :
                         w_sum_wide[ACC_W]  ? c_SUM_MIN : c_SUM_MAX;

    // A beat that arrives with the counter already at all-ones is lost from
    // the count, so that beat is flagged as an overflow.
    assign w_cnt_full   = &r_count;
    assign w_count_next = w_cnt_full ? r_count : r_count + CNT_W'(1);
    assign w_ovf_next   = r_ovf | w_sum_clamp | w_cnt_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && bus.in_last) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_out_fire)              w_state_next = ST_ACCUM;
            default:                               w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_last) begin
                r_out_sum   <= w_acc_next;
                r_out_count <= w_count_next;
                r_out_ovf   <= w_ovf_next;
                r_acc       <= '0;
                r_count     <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc       <= w_acc_next;
                r_count     <= w_count_next;
                r_ovf       <= w_ovf_next;
            end
        end
    end

    // Handshake outputs are pure state decode, so neither depends on out_ready.
    assign bus.in_ready     = (r_state == ST_ACCUM);
    assign bus.out_valid    = (r_state == ST_HOLD);
    assign bus.out_sum      = r_out_sum;
    assign bus.out_count    = r_out_count;
    assign bus.out_overflow = r_out_ovf;
endmodule
`default_nettype wire
